paddle_ai_driver: RTL and testbench

Computer opponent for the Pong datapath: generates the `up`/`down` command pulses that drive a paddle position register, closing the loop from ball position to paddle motion. It reads the ball Y coordinate, the ball's horizontal direction and the current paddle Y fed back from the paddle register. After a reaction delay it steps the paddle toward the ball at a fixed, rate-limited speed so the opponent stays beatable. Sits between the ball physics block and the right-hand paddle register, in place of the player buttons.

---
 rtl/paddle_ai_driver.sv | 138 +++++++++++++
 tb/tb_paddle_ai_driver.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/paddle_ai_driver.sv
// rtl/paddle_ai_driver.sv - Pong computer opponent: rate-limited up/down pulses steering a paddle toward the ball.
// Optional return-to-centre behaviour while the ball moves away is enabled by defining PADDLE_AI_RECENTER_EN.
module paddle_ai_driver #(
  parameter int STEP_DIV    = 200000,
  parameter int REACT_DELAY = 4,
  parameter int DEAD_ZONE   = 2,
  parameter int PADDLE_H    = 80,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = 400,
  parameter int CENTER_Y    = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [8:0] ballY,
  input  logic       ballToward,
  input  logic [8:0] paddleY,
  output logic       up,
  output logic       down,
  output logic       tracking
);

  localparam int CW = (STEP_DIV <= 2) ? 1 : $clog2(STEP_DIV);
  localparam int DW = (REACT_DELAY < 1) ? 1 : $clog2(REACT_DELAY + 1);
  localparam logic [CW-1:0] TICK_LAST   = CW'(STEP_DIV - 1);
  localparam logic [DW-1:0] DELAY_LOAD  = DW'(REACT_DELAY);
  localparam logic [9:0]    HALF_H      = 10'(PADDLE_H / 2);
  localparam logic [9:0]    DZ          = 10'(DEAD_ZONE);
  localparam logic [9:0]    LIM_LO      = 10'(Y_MIN);
  localparam logic [9:0]    LIM_HI      = 10'(Y_MAX);
  localparam logic [9:0]    REST_CENTRE = 10'(CENTER_Y + PADDLE_H / 2);

  typedef enum logic [1:0] {
    IDLE,
    REACT,
`ifdef PADDLE_AI_RECENTER_EN
    TRACK,
    RECENTER
`else
    TRACK
`endif
  } state_e;

  state_e          state_q, state_d, away_state, enter_state;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   dly_q, dly_d;
  logic            up_q, up_d, down_q, down_d, trk_q;
  logic            tick, recentering, steering;
  logic [9:0]      centre, aim;

  always_comb begin
    tick  = (cnt_q == TICK_LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_comb begin
`ifdef PADDLE_AI_RECENTER_EN
    away_state  = RECENTER;
    recentering = (state_q == RECENTER);
`else
    away_state  = IDLE;
    recentering = 1'b0;
`endif
    if (REACT_DELAY == 0) enter_state = TRACK;
    else                  enter_state = REACT;
  end

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (ballToward) begin
            state_d = enter_state;
            dly_d   = DELAY_LOAD;
          end else begin
            state_d = away_state;
          end
        end
        REACT: begin
          if (!ballToward) begin
            state_d = away_state;
          end else if (tick) begin
            dly_d = dly_q - 1'b1;
            if (dly_q == DW'(1)) state_d = TRACK;
          end
        end
        TRACK: begin
          if (!ballToward) state_d = away_state;
        end
`ifdef PADDLE_AI_RECENTER_EN
        RECENTER: begin
          if (ballToward) begin
            state_d = enter_state;
            dly_d   = DELAY_LOAD;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  // Steer only on a tick where the state holds; any transition that cycle suppresses the pulse.
  always_comb begin
    centre   = {1'b0, paddleY} + HALF_H;
    aim      = recentering ? REST_CENTRE : {1'b0, ballY};
    steering = tick && (state_d == state_q) && ((state_q == TRACK) || recentering);
    down_d   = steering && (aim > centre + DZ) && ({1'b0, paddleY} < LIM_HI);
    up_d     = steering && !down_d && (centre > aim + DZ) && ({1'b0, paddleY} > LIM_LO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dly_q   <= '0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      trk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
      up_q    <= up_d;
      down_q  <= down_d;
      trk_q   <= (state_d == TRACK);
    end
  end

  assign up       = up_q;
  assign down     = down_q;
  assign tracking = trk_q;

endmodule

// File: tb/tb_paddle_ai_driver.sv
// tb/tb_paddle_ai_driver.sv - randomized and directed self-checking bench for paddle_ai_driver with a closed paddle loop.
module tb_paddle_ai_driver;

  localparam int SD = 4, RD = 2, PH = 80, DZ = 2, YMIN = 0, YMAX = 400, CY = 200;
`ifdef PADDLE_AI_RECENTER_EN
  localparam bit RECEN = 1'b1;
`else
  localparam bit RECEN = 1'b0;
`endif
  localparam int M_IDLE = 0, M_REACT = 1, M_TRACK = 2, M_REC = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       ballToward = 1'b0;
  logic [8:0] ballY = '0;
  logic [8:0] paddleY = '0;
  logic       up, down, tracking;

  always #5 clk = ~clk;

  paddle_ai_driver #(
    .STEP_DIV(SD), .REACT_DELAY(RD), .DEAD_ZONE(DZ), .PADDLE_H(PH),
    .Y_MIN(YMIN), .Y_MAX(YMAX), .CENTER_Y(CY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ballY(ballY),
    .ballToward(ballToward), .paddleY(paddleY),
    .up(up), .down(down), .tracking(tracking)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int m_cnt, m_mode, m_wait;
  bit e_up, e_down, e_trk;
  bit follow;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_mode = M_IDLE; m_wait = 0;
    e_up = 1'b0; e_down = 1'b0; e_trk = 1'b0;
  endtask

  // Reference behaviour: evaluated once per rising edge from the inputs seen during the ending cycle.
  task automatic model_edge();
    bit tick = (m_cnt == SD - 1);
    int nm   = m_mode;
    int away = RECEN ? M_REC : M_IDLE;
    int ctr  = int'(paddleY) + PH / 2;
    bit want_down = 1'b0;
    bit want_up   = 1'b0;
    if (!enable) nm = M_IDLE;
    else if (m_mode == M_IDLE || m_mode == M_REC) begin
      if (ballToward) begin
        nm = (RD == 0) ? M_TRACK : M_REACT;
        m_wait = RD;
      end else nm = away;
    end else if (!ballToward) nm = away;
    else if (m_mode == M_REACT && tick) begin
      m_wait--;
      if (m_wait == 0) nm = M_TRACK;
    end
    e_up = 1'b0; e_down = 1'b0;
    if (tick && nm == m_mode) begin
      if (m_mode == M_TRACK) begin
        want_down = int'(ballY) > ctr + DZ;
        want_up   = ctr > int'(ballY) + DZ;
      end else if (m_mode == M_REC) begin
        want_down = CY > int'(paddleY) + DZ;
        want_up   = int'(paddleY) > CY + DZ;
      end
      if (want_down && int'(paddleY) < YMAX) e_down = 1'b1;
      else if (want_up && int'(paddleY) > YMIN) e_up = 1'b1;
    end
    m_mode = nm;
    e_trk  = (nm == M_TRACK);
    m_cnt  = (m_cnt + 1) % SD;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    else model_reset();
    #1;
    check("up", up, e_up);
    check("down", down, e_down);
    check("tracking", tracking, e_trk);
    check("exclusive", up & down, 0);
    if (follow) begin
      if (up && paddleY > 0) paddleY = paddleY - 1'b1;
      if (down && paddleY < 9'd511) paddleY = paddleY + 1'b1;
    end
  endtask

  task automatic run(input int n, output int nu, output int nd);
    nu = 0; nd = 0;
    for (int i = 0; i < n; i++) begin
      step();
      nu += int'(up);
      nd += int'(down);
    end
  endtask

  initial begin
    int nu, nd, k;
    follow = 1'b0;
    model_reset();

    rst_n = 1'b0; enable = 1'b1; ballToward = 1'b1; ballY = 9'd300; paddleY = 9'd100;
    repeat (3) step();
    rst_n = 1'b1;
    run(4, nu, nd);
    check("post_reset_up", nu, 0);
    check("post_reset_down", nd, 0);

    k = 0;
    while (!tracking && k < 20) begin step(); k++; end
    check("track_rise", tracking, 1);
    follow = 1'b1;
    run(16, nu, nd);
    check("track_downs", nd, 4);
    check("track_ups", nu, 0);

    follow = 1'b0; paddleY = 9'd100;
    for (int b = 138; b <= 142; b++) begin
      ballY = 9'(b);
      run(8, nu, nd);
      check("deadzone_pulses", nu + nd, 0);
    end
    ballY = 9'd137; run(8, nu, nd);
    check("dz_low_up", nu, 2);
    check("dz_low_down", nd, 0);
    ballY = 9'd143; run(8, nu, nd);
    check("dz_high_down", nd, 2);
    check("dz_high_up", nu, 0);

    paddleY = 9'd400; ballY = 9'd479; run(8, nu, nd);
    check("limit_bottom", nu + nd, 0);
    paddleY = 9'd0; ballY = 9'd0; run(8, nu, nd);
    check("limit_top", nu + nd, 0);

    paddleY = 9'd100; ballY = 9'd300;
    k = 0;
    while (m_cnt != SD - 1 && k < 8) begin step(); k++; end
    check("abort_align", m_cnt, SD - 1);
    check("abort_pre_trk", tracking, 1);
    enable = 1'b0;
    step();
    check("abort_no_down", down, 0);
    check("abort_trk_fall", tracking, 0);
    run(8, nu, nd);
    check("abort_idle", nu + nd, 0);

    enable = 1'b1;
    k = 0;
    while (!down && k < 40) begin step(); k++; end
    check("pulse_seen", down, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_down", down, 0);
    check("async_rst_up", up, 0);
    check("async_rst_trk", tracking, 0);
    repeat (2) step();
    rst_n = 1'b1;

    ballToward = 1'b0; paddleY = 9'd150; follow = 1'b1;
    run(260, nu, nd);
    check("recenter_final", paddleY, RECEN ? 198 : 150);
    check("recenter_downs", nd, RECEN ? 48 : 0);
    check("recenter_ups", nu, 0);

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) < 3) ballToward = ~ballToward;
      if (enable && $urandom_range(0, 99) < 2) enable = 1'b0;
      else if (!enable && $urandom_range(0, 99) < 30) enable = 1'b1;
      if ($urandom_range(0, 99) < 10) ballY = 9'($urandom_range(0, 479));
      if ($urandom_range(0, 99) < 1) paddleY = 9'($urandom_range(0, 420));
      if (rst_n && $urandom_range(0, 999) < 2) rst_n = 1'b0;
      else rst_n = 1'b1;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
